// File: rtl/usr_pkg.sv
// Shared mode and FSM encodings for the universal shift register.
package usr_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True for the modes that step through the shift datapath.
    function automatic logic is_shift(input mode_e m);
        return !(m == MODE_HOLD || m == MODE_LOAD || m == MODE_CLEAR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Single-step shift/rotate datapath; purely combinational.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             shift_out
);

    always_comb begin
        q_next    = q;
        shift_out = 1'b0;
        case (mode_e'(mode))
            MODE_SHL: begin
                q_next    = {q[WIDTH-2:0], ser_in};
                shift_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {ser_in, q[WIDTH-1:1]};
                shift_out = q[0];
            end
            MODE_ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                shift_out = q[0];
            end
            MODE_ASR: begin
                q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                shift_out = q[0];
            end
            default: begin
                q_next    = q;
                shift_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-mode WIDTH-bit register: load/clear in one edge, shifts one step per clock
// with a start/busy/done handshake.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned    WIDTH     = 8,
    parameter int unsigned    AMT_W     = $clog2(WIDTH) + 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e             state;
    mode_e              run_mode;
    logic [AMT_W-1:0]   remaining;
    logic [2:0]         step_mode_c;
    logic [WIDTH-1:0]   step_q_c;
    logic               step_out_c;

    // In IDLE the incoming opcode drives the first step; in RUN the latched one.
    assign step_mode_c = (state == ST_RUN) ? 3'(run_mode) : mode;

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q         (Q),
        .mode      (step_mode_c),
        .ser_in    (ser_in),
        .q_next    (step_q_c),
        .shift_out (step_out_c)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            run_mode  <= MODE_HOLD;
            remaining <= '0;
            Q         <= RESET_VAL;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (mode_e'(mode))
                            MODE_HOLD:  done <= 1'b1;
                            MODE_LOAD: begin
                                Q    <= D;
                                done <= 1'b1;
                            end
                            MODE_CLEAR: begin
                                Q    <= RESET_VAL;
                                done <= 1'b1;
                            end
                            default: begin
                                if (amount == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    Q       <= step_q_c;
                                    ser_out <= step_out_c;
                                    if (amount == AMT_W'(1)) begin
                                        done <= 1'b1;
                                    end else begin
                                        state     <= ST_RUN;
                                        busy      <= 1'b1;
                                        remaining <= AMT_W'(amount - AMT_W'(1));
                                        run_mode  <= mode_e'(mode);
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    Q         <= step_q_c;
                    ser_out   <= step_out_c;
                    remaining <= AMT_W'(remaining - AMT_W'(1));
                    // Last step: hand back to IDLE and flag the result for next cycle.
                    if (remaining == AMT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg with an arithmetic reference model
// compared against the DUT on every falling edge.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned AMT_W = 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic [W-1:0]     D = '0;
    logic [AMT_W-1:0] amount = '0;
    logic             ser_in = 1'b0;
    logic [W-1:0]     Q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state: plain integers, remaining-step count only.
    int m_q = 0, m_so = 0, m_busy = 0, m_done = 0, m_rem = 0, m_mode = 0;

    universal_shift_reg #(.WIDTH(W), .AMT_W(AMT_W), .RESET_VAL(8'h00)) dut (
        .CLK(CLK), .reset(reset), .start(start), .mode(mode), .D(D),
        .amount(amount), .ser_in(ser_in), .Q(Q), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic int step_q(input int m, input int q, input int si);
        case (m)
            2: return (q * 2) % 256 + si;
            3: return q / 2 + si * 128;
            4: return (q * 2) % 256 + q / 128;
            5: return q / 2 + (q % 2) * 128;
            6: return q / 2 + (q / 128) * 128;
            default: return q;
        endcase
    endfunction

    function automatic int step_so(input int m, input int q);
        if (m == 2 || m == 4) return q / 128;
        return q % 2;
    endfunction

    initial forever begin
        @(posedge CLK or negedge reset);
        if (!reset) begin
            m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_so  = step_so(m_mode, m_q);
                m_q   = step_q(m_mode, m_q, int'(ser_in));
                m_rem = m_rem - 1;
                if (m_rem == 0) m_done = 1;
            end else if (start) begin
                if (mode == 3'd0) m_done = 1;
                else if (mode == 3'd1) begin m_q = int'(D); m_done = 1; end
                else if (mode == 3'd7) begin m_q = 0; m_done = 1; end
                else if (amount == 0) m_done = 1;
                else begin
                    m_mode = int'(mode);
                    m_so   = step_so(m_mode, m_q);
                    m_q    = step_q(m_mode, m_q, int'(ser_in));
                    m_rem  = int'(amount) - 1;
                    if (m_rem == 0) m_done = 1;
                end
            end
            m_busy = (m_rem > 0) ? 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge CLK);
        if (check_en) begin
            chk("cyc_q", 32'(Q), 32'(m_q));
            chk("cyc_ser_out", 32'(ser_out), 32'(m_so));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
        end
    end

    // Drive a command for one cycle; returns at the falling edge of cycle t+1.
    task automatic issue(input logic [2:0] m, input logic [7:0] d, input logic [3:0] a);
        start = 1'b1; mode = m; D = d; amount = a;
        @(negedge CLK);
        start = 1'b0; mode = 3'($urandom); D = 8'($urandom); amount = 4'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge CLK);
            lat++;
        end
        if (done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
        end
    endtask

    task automatic cmd(input string name, input logic [2:0] m, input logic [7:0] d,
                       input logic [3:0] a, input int exp_q, input int exp_lat);
        int lat, bcnt;
        issue(m, d, a);
        wait_done(lat, bcnt);
        chk({name, "_q"}, 32'(Q), 32'(exp_q));
        chk({name, "_model_q"}, 32'(m_q), 32'(exp_q));
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
    endtask

    initial begin
        int lat, bcnt, npulse;
        reset = 1'b0;
        @(negedge CLK);
        check_en = 1'b1;
        chk("reset_q", 32'(Q), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);

        // Plan 1: load and one-cycle done pulse
        issue(3'(MODE_LOAD), 8'hA5, 4'd0);
        chk("load_q", 32'(Q), 32'hA5);
        chk("load_done", 32'(done), 32'h1);
        @(negedge CLK);
        chk("load_done_clear", 32'(done), 32'h0);

        // Plan 2: rotate left 3
        cmd("rol3", 3'(MODE_ROL), 8'h00, 4'd3, 8'h2D, 3);
        chk("rol3_ser_out", 32'(ser_out), 32'h1);
        @(negedge CLK);

        // Plan 3: arithmetic shift and single-step serial fill
        cmd("ld80", 3'(MODE_LOAD), 8'h80, 4'd0, 8'h80, 1);
        cmd("asr2", 3'(MODE_ASR), 8'h00, 4'd2, 8'hE0, 2);
        cmd("clr", 3'(MODE_CLEAR), 8'h00, 4'd0, 8'h00, 1);
        ser_in = 1'b1;
        cmd("shr1", 3'(MODE_SHR), 8'h00, 4'd1, 8'h80, 1);
        ser_in = 1'b0;
        @(negedge CLK);

        // Plan 4: start while busy is ignored; zero-bubble load in the done cycle
        cmd("ld3c", 3'(MODE_LOAD), 8'h3C, 4'd0, 8'h3C, 1);
        issue(3'(MODE_ROR), 8'h00, 4'd4);
        start = 1'b1; mode = 3'(MODE_LOAD); D = 8'hFF; amount = 4'd1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ror4_q", 32'(Q), 32'hC3);
        chk("ror4_latency_after_ignored", 32'(lat), 32'd3);
        issue(3'(MODE_LOAD), 8'hFF, 4'd0);
        chk("b2b_load_q", 32'(Q), 32'hFF);
        chk("b2b_load_done", 32'(done), 32'h1);
        @(negedge CLK);

        // Plan 5: reset during a running shift aborts it with no done pulse
        cmd("ld81", 3'(MODE_LOAD), 8'h81, 4'd0, 8'h81, 1);
        ser_in = 1'b1;
        issue(3'(MODE_SHL), 8'h00, 4'd6);
        @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        chk("abort_q", 32'(Q), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (done === 1'b1) npulse++;
        end
        chk("abort_no_done", 32'(npulse), 32'd0);
        chk("abort_idle", 32'(busy), 32'h0);
        ser_in = 1'b0;

        // Plan 6: zero amount and full-width rotate
        cmd("ld5a", 3'(MODE_LOAD), 8'h5A, 4'd0, 8'h5A, 1);
        cmd("shl0", 3'(MODE_SHL), 8'h00, 4'd0, 8'h5A, 1);
        cmd("hold", 3'(MODE_HOLD), 8'h11, 4'd5, 8'h5A, 1);
        cmd("ld3c_b", 3'(MODE_LOAD), 8'h3C, 4'd0, 8'h3C, 1);
        cmd("ror8", 3'(MODE_ROR), 8'h00, 4'd8, 8'h3C, 8);

        // Amounts beyond WIDTH saturate or fill
        ser_in = 1'b1;
        cmd("clr2", 3'(MODE_CLEAR), 8'h00, 4'd0, 8'h00, 1);
        cmd("shl10", 3'(MODE_SHL), 8'h00, 4'd10, 8'hFF, 10);
        ser_in = 1'b0;
        cmd("ld80b", 3'(MODE_LOAD), 8'h80, 4'd0, 8'h80, 1);
        cmd("asr12", 3'(MODE_ASR), 8'h00, 4'd12, 8'hFF, 12);
        cmd("ld96", 3'(MODE_LOAD), 8'h96, 4'd0, 8'h96, 1);
        cmd("rol11", 3'(MODE_ROL), 8'h00, 4'd11, 8'hB4, 11);

        // ser_in sampled on every step edge rather than at accept
        cmd("clr3", 3'(MODE_CLEAR), 8'h00, 4'd0, 8'h00, 1);
        ser_in = 1'b1;
        issue(3'(MODE_SHL), 8'h00, 4'd4);
        ser_in = 1'b0;
        @(negedge CLK);
        ser_in = 1'b1;
        @(negedge CLK);
        ser_in = 1'b1;
        @(negedge CLK);
        chk("serial_q", 32'(Q), 32'h0B);
        chk("serial_done", 32'(done), 32'h1);
        ser_in = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
